// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int NREQ    = 3;
  localparam int REQ_IF  = 0;
  localparam int REQ_LS  = 1;
  localparam int REQ_DBG = 2;

  localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// rtl/mem_arb_prio_sel.sv - fixed-priority one-hot selector with loader promotion
module mem_arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            starve,
  output logic [NREQ-1:0] grant
);

  // load/store > fetch > loader, unless the loader has been starved
  always_comb begin
    grant = '0;
    if (starve && req_valid[REQ_DBG]) begin
      grant[REQ_DBG] = 1'b1;
    end else if (req_valid[REQ_LS]) begin
      grant[REQ_LS] = 1'b1;
    end else if (req_valid[REQ_IF]) begin
      grant[REQ_IF] = 1'b1;
    end else if (req_valid[REQ_DBG]) begin
      grant[REQ_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way arbiter onto a single-port synchronous memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ*DATA_W/8-1:0]   req_wmask,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wmask,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy
);

  localparam int MASK_W = DATA_W / 8;

  state_t state, state_nxt;

  logic [NREQ-1:0]     owner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;
  logic [2:0]          lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [DATA_W-1:0]   rdata_q;

  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     hs;
  logic                starve;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [MASK_W-1:0]   sel_wmask;
  logic                rd_last;

  assign starve  = int'(starve_cnt) >= STARVE_LIMIT;
  assign rd_last = (lat_cnt == 3'(RD_LATENCY));

  mem_arb_prio_sel u_prio_sel (
    .req_valid (req_valid),
    .starve    (starve),
    .grant     (grant)
  );

  assign hs = req_valid & req_ready;

  // payload of the current winner; grant is one-hot so at most one slice matches
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wmask = req_wmask[i*MASK_W +: MASK_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|(req_valid & grant)) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_wmask = lat_we ? lat_wmask : '0;
        state_nxt = lat_we ? DONE : WAIT;
      end
      WAIT: begin
        if (rd_last) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (state == IDLE && |hs) begin
      owner     <= hs;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_wmask <= sel_wmask;
    end
  end

  // counts arbitrations the loader lost while waiting; saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!req_valid[REQ_DBG] || hs[REQ_DBG]) begin
        starve_cnt <= '0;
      end else if (|hs && starve_cnt != '1) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= 3'd1;
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // read data is held across write completions until the next read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state == WAIT && rd_last) begin
      rdata_q <= mem_rdata;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [2:0]  req_valid = '0;
  logic [2:0]  req_we = '0;
  logic [95:0] req_addr = '0;
  logic [95:0] req_wdata = '0;
  logic [11:0] req_wmask = '0;
  logic [2:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;
  logic [3:0]  mem_wmask;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  logic [2:0]  r3_valid = '0;
  logic [95:0] r3_addr = '0;
  logic [2:0]  r3_ready, r3_rsp_valid;
  logic [31:0] r3_rsp_rdata, r3_mem_addr, r3_mem_wdata, r3_mem_rdata;
  logic        r3_mem_en, r3_mem_we, r3_busy;
  logic [3:0]  r3_mem_wmask;

  mem_arbiter #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_we(3'b000), .req_addr(r3_addr),
    .req_wdata(96'h0), .req_wmask(12'h0),
    .req_ready(r3_ready), .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata),
    .mem_en(r3_mem_en), .mem_we(r3_mem_we), .mem_addr(r3_mem_addr),
    .mem_wdata(r3_mem_wdata), .mem_wmask(r3_mem_wmask), .mem_rdata(r3_mem_rdata),
    .busy(r3_busy)
  );

  // memory model for dut: one-cycle read latency, garbage when no read is due
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        rd_v = 1'b0;
  logic [31:0] rd_d = '0;

  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    if (mem_en && mem_we) begin
      w = mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      mem[mem_addr[9:2]] <= w;
    end
    rd_v <= mem_en && !mem_we;
    rd_d <= mem[mem_addr[9:2]];
  end
  assign mem_rdata = rd_v ? rd_d : (32'hBADC_0DE5 ^ 32'(cyc));

  // memory model for dut3: three-cycle read latency
  logic [2:0]  p_v = '0;
  logic [31:0] p_d [3];
  always @(posedge clk) begin
    p_v    <= {p_v[1:0], r3_mem_en & ~r3_mem_we};
    p_d[0] <= 32'hC0DE_0000 | {16'h0, r3_mem_addr[15:0]};
    p_d[1] <= p_d[0];
    p_d[2] <= p_d[1];
  end
  assign r3_mem_rdata = p_v[2] ? p_d[2] : (32'hBAD0_0000 ^ 32'(cyc));

  typedef struct {
    logic [2:0]  owner;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  rsp_t sb[$];
  int   grant_log[$];

  logic [2:0]  drop_mask = '0;
  logic [2:0]  sticky = '0;
  bit          cur_active = 0;
  int          cur_t, cur_done, last_gnt = -100;
  logic [2:0]  cur_owner;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, last_rd = '0;
  logic [3:0]  cur_wmask;
  int          st_cnt = 0;

  // a requester withdraws its valid right after its handshake unless held sticky
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~(drop_mask & ~sticky);
    drop_mask = '0;
  end

  always @(negedge clk) begin : monitor
    logic [2:0]  hs, exp_gnt, exp_rsp;
    logic [31:0] w;
    bit          idle_exp;
    int          idx;
    rsp_t        r;
    if (!rst_n) begin
      cur_active = 0;
      sb.delete();
      st_cnt   = 0;
      last_rd  = '0;
      last_gnt = -100;
    end else begin
      idle_exp = !cur_active;
      if (cur_active && cyc == cur_t + 1) begin
        check("mem_en", mem_en, 1);
        check("mem_we", mem_we, cur_we);
        check("mem_addr", mem_addr, cur_addr);
        if (cur_we) begin
          check("mem_wdata", mem_wdata, cur_wdata);
          check("mem_wmask", mem_wmask, cur_wmask);
        end else begin
          check("mem_wmask_rd", mem_wmask, 0);
        end
      end else begin
        check("mem_quiet", {mem_en, mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
      end
      check("busy", busy, cur_active);
      exp_rsp = (cur_active && cyc == cur_done) ? cur_owner : 3'b000;
      check("rsp_valid", rsp_valid, exp_rsp);
      if (rsp_valid != 0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          r = sb.pop_front();
          check("rsp_owner", rsp_valid, r.owner);
          check("rsp_rdata", rsp_rdata, r.data);
          check("rsp_cycle", cyc, r.cyc);
        end
      end
      if (cur_active && cyc >= cur_done) cur_active = 0;

      if (idle_exp) begin
        if (st_cnt >= 4 && req_valid[2]) exp_gnt = 3'b100;
        else if (req_valid[1])           exp_gnt = 3'b010;
        else if (req_valid[0])           exp_gnt = 3'b001;
        else if (req_valid[2])           exp_gnt = 3'b100;
        else                             exp_gnt = 3'b000;
        check("req_ready", req_ready, exp_gnt);
      end else begin
        check("req_ready_busy", req_ready, 0);
      end

      hs = req_valid & req_ready;
      if (idle_exp) begin
        if (!req_valid[2] || hs[2]) st_cnt = 0;
        else if (hs != 0 && st_cnt < 7) st_cnt++;
      end
      if (hs != 0) begin
        check("hs_onehot", $onehot(hs), 1);
        idx = hs[0] ? 0 : (hs[1] ? 1 : 2);
        check("grant_gap_ok", (cyc - last_gnt) >= 3, 1);
        last_gnt = cyc;
        grant_log.push_back(idx);
        cur_active = 1;
        cur_t      = cyc;
        cur_owner  = hs;
        cur_we     = req_we[idx];
        cur_addr   = req_addr[idx*32 +: 32];
        cur_wdata  = req_wdata[idx*32 +: 32];
        cur_wmask  = req_wmask[idx*4 +: 4];
        cur_done   = cyc + (cur_we ? 2 : 3);
        if (cur_we) begin
          w = ref_mem[cur_addr[9:2]];
          for (int b = 0; b < 4; b++)
            if (cur_wmask[b]) w[b*8 +: 8] = cur_wdata[b*8 +: 8];
          ref_mem[cur_addr[9:2]] = w;
          sb.push_back('{owner: hs, data: last_rd, cyc: cur_done});
        end else begin
          last_rd = ref_mem[cur_addr[9:2]];
          sb.push_back('{owner: hs, data: last_rd, cyc: cur_done});
        end
        drop_mask = drop_mask | hs;
      end
    end
  end

  task automatic post(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask);
    req_we[i]              = we;
    req_addr[i*32 +: 32]   = addr;
    req_wdata[i*32 +: 32]  = wdata;
    req_wmask[i*4 +: 4]    = wmask;
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(req_valid == 0 && !cur_active && sb.size() == 0) && n < budget);
    if (n >= budget) check("quiet_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n, t;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, busy}, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // fetch read of 0x10, write from load/store, read-back of the merged word
    @(posedge clk); #1; post(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_quiet(50);
    @(posedge clk); #1; post(1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011);
    wait_quiet(50);
    @(posedge clk); #1; post(0, 1'b0, 32'h100, 32'h0, 4'h0);
    wait_quiet(50);

    // contention: all three at once
    grant_log.delete();
    @(posedge clk); #1;
    post(0, 1'b0, 32'h10, 32'h0, 4'h0);
    post(1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b1111);
    post(2, 1'b1, 32'h300, 32'hA5A5_5A5A, 4'b1100);
    wait_quiet(100);
    check("cont_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("cont_first", grant_log[0], 1);
      check("cont_second", grant_log[1], 0);
      check("cont_third", grant_log[2], 2);
    end

    // starvation: load/store held, loader waiting
    grant_log.delete();
    sticky = 3'b010;
    @(posedge clk); #1;
    post(1, 1'b0, 32'h10, 32'h0, 4'h0);
    post(2, 1'b0, 32'h300, 32'h0, 4'h0);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (grant_log.size() < 5 && n < 100);
    check("starve_grants", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 4; k++) check("starve_ls_win", grant_log[k], 1);
      check("starve_loader_win", grant_log[4], 2);
      check("starve_cnt_cleared", dut.starve_cnt, 0);
    end
    sticky = 3'b000;
    wait_quiet(100);

    // asynchronous reset in the middle of a read
    @(posedge clk); #1; post(0, 1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!cur_active && n < 20);
    check("rst_read_started", cur_active, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready_rsp", {req_ready, rsp_valid}, 0);
    check("midrst_rdata", rsp_rdata, 0);
    check("midrst_mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1; post(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_quiet(50);

    // RD_LATENCY=3 instance
    @(posedge clk); #1;
    r3_addr[31:0] = 32'h20;
    r3_valid      = 3'b001;
    n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
      if (r3_ready[0]) t = cyc;
    end while (t < 0 && n < 20);
    check("l3_accept", t >= 0, 1);
    @(posedge clk); #1; r3_valid = 3'b000;
    if (t >= 0) begin
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check("l3_rsp_valid", r3_rsp_valid, (cyc == t + 5) ? 3'b001 : 3'b000);
        if (cyc == t + 5) check("l3_rsp_rdata", r3_rsp_rdata, 32'hC0DE_0020);
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous instruction/data memory between three requesters of the multi-cycle core:
  - instruction fetch (FETCH state),
  - load/store (MEM_ACCESS state),
  - debug/program loader.
- Valid/ready request handshake, registered one-cycle response pulse, fixed read latency.
- Fixed priority, with a starvation guard for the loader.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width; a multiple of 8.
- RD_LATENCY, 1, cycles from the mem_en read cycle to valid mem_rdata; must be 1..7.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the loader is promoted to top priority.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  3  per requester: request pending. Bit 0 = fetch, 1 = load/store, 2 = loader.
- req_we  in  3  per requester: 1 = write.
- req_addr  in  3*ADDR_W  per-requester address; slice i belongs to requester i.
- req_wdata  in  3*DATA_W  per-requester write data.
- req_wmask  in  3*DATA_W/8  per-requester byte enables.
- req_ready  out  3  one-hot grant; request accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  3  one-hot, one-cycle completion pulse to the owner.
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, RD_LATENCY cycles after a read strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- **Reset** (asynchronous, any time, including mid-transaction):
  - state goes to IDLE; starvation counter = 0; rsp_rdata register = 0.
  - All outputs are 0. An in-flight transaction is dropped and no rsp_valid is produced.
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - req_ready is combinational, one-hot, to the winner; it is 0 if no req_valid is set.
  - On handshake (cycle T): latch owner, we, addr, wdata and wmask, then go to ISSUE.
- **ISSUE** (T+1):
  - mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values.
  - mem_wmask = latched wmask for writes, 0 for reads.
  - Write: go to DONE. Read: go to WAIT with the latency counter = 1.
- **WAIT:** RD_LATENCY cycles (T+2 .. T+1+RD_LATENCY).
  - Counter increments each cycle.
  - When counter == RD_LATENCY, register mem_rdata into rsp_rdata and go to DONE.
- **DONE:**
  - rsp_valid[owner] = 1 for exactly one cycle; then go to IDLE.
  - No grant is issued in DONE, so back-to-back accepts are ≥ 1 idle cycle apart.
- **Latency:**
  - Write: accept T, rsp_valid at T+2.
  - Read: accept T, rsp_valid at T+2+RD_LATENCY (T+3 at the default).
- **rsp_rdata** holds its value until the next read capture. Write completions do not change it.
- **Memory outputs** (mem_en, mem_we, mem_addr, mem_wdata, mem_wmask) are 0 in every state except ISSUE.
- **Priority:** load/store > fetch > loader.
  - Exception: if the starvation counter ≥ STARVE_LIMIT and req_valid[2] is set, the loader wins outright.
- **Starvation counter** (saturating, 3 bits), updated on each IDLE handshake:
  - Increment when req_valid[2] is set and another requester is granted.
  - Clear when the loader is granted.
  - Clear whenever req_valid[2] is low in IDLE.
- **Requester protocol:**
  - Requesters hold req_valid and payload stable until ready; the arbiter does not check this.
  - Dropping req_valid before the grant simply withdraws the request.
- **Requests during ISSUE/WAIT/DONE** see req_ready = 0 and are not queued.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11.
  - Constants: NREQ=3, REQ_IF=0, REQ_LS=1, REQ_DBG=2.
- One combinational sub-module, mem_arb_prio_sel:
  - Inputs: req_valid[2:0], starve flag.
  - Output: one-hot grant.
- The FSM, latches and counters stay in mem_arbiter.

Test Plan:
- **Read, fetch only:**
  - Stimulus: req_valid=3'b001, addr 0x0000_0010; memory model returns 0xDEAD_BEEF one cycle after the strobe.
  - Response: req_ready=001 at T; mem_en=1, mem_we=0, mem_addr=0x10 at T+1; rsp_valid=001 and rsp_rdata=0xDEAD_BEEF at T+3; busy high T+1..T+3.
- **Write, load/store:**
  - Stimulus: we=1, addr 0x100, wdata 0x1234_5678, wmask 4'b0011.
  - Response: mem_wmask=0011 at T+1; rsp_valid=010 at T+2; rsp_rdata unchanged.
- **Contention:**
  - Stimulus: req_valid=3'b111 held; each requester drops its valid after its own handshake.
  - Response: grant order load/store, fetch, loader; rsp_valid pulses in that order; no two grants within 3 cycles.
- **Starvation:**
  - Stimulus: STARVE_LIMIT=4; loader and load/store valid continuously.
  - Response: load/store wins 4 times, the loader wins the 5th arbitration, and the counter reads 0 afterwards.
- **Reset mid-read:**
  - Stimulus: rst_n low during WAIT.
  - Response: all outputs 0 immediately (asynchronous); no rsp_valid after release; a fresh read afterwards completes normally.
- **RD_LATENCY=3 variant:**
  - Stimulus: single read.
  - Response: rsp_valid at T+5; data captured from the memory model's 3rd post-strobe cycle.
